sl_rx_fifo: RTL and testbench
=============================

// Module: sl_rx_fifo
// PURPOSE
//  Parametrised next-generation serial-line (SL) receiver on the two-wire SL bus (zeroes/ones lines).
//  Decodes words of programmable length (1..MAX_BITS) with optional odd parity and buffers them,
//  with per-word error codes, in a DEPTH-entry FIFO drained through a valid/ready port.
//  Sits between the SL pins and the APB register block (the APB block pops the FIFO and reads status).
// PARAMETERS
//  MAX_BITS    32   max data bits per word; m_data width
//  DEPTH       4    FIFO entries; power of 2, >=2
//  STROBE_POS  8    clk cycles from bit-start to sampling strobe
//  TIMEOUT     256  watchdog limit in clk cycles (used only with SL_RX_WATCHDOG_EN)
// PORTS
//  clk         in   1                     system clock, 16 MHz
//  rst         in   1                     asynchronous reset, active-high
//  sl0_i       in   1                     SL zeroes line (async, idle 1)
//  sl1_i       in   1                     SL ones line (async, idle 1)
//  rx_en       in   1                     receiver enable
//  cfg_len     in   $clog2(MAX_BITS+1)    data bits per word
//  cfg_par_en  in   1                     1 = odd parity bit follows data
//  m_valid     out  1                     FIFO head valid
//  m_ready     in   1                     consumer pops head when m_valid&m_ready
//  m_data      out  MAX_BITS              head word, right-aligned, upper bits 0
//  m_err       out  3                     head error code (sl_pkg::ERR_*)
//  fifo_level  out  $clog2(DEPTH+1)       occupied entries
//  busy        out  1                     word in progress (state != IDLE)
//  ovf         out  1                     sticky: word dropped because FIFO full
//  ovf_clr     in   1                     clears ovf (set wins on same cycle)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, FIFO empty, sync flops = 1 (idle line).
//  - sl0_i/sl1_i pass 2-flop synchronisers (2 clk latency); decoding uses synced {sl1,sl0}.
//  - Symbols: 11 idle; 01 = ONE (ones line low); 10 = ZERO; 00 = STOP.
//  - Bit start = synced lines leave 11. Pulse counter counts to STROBE_POS; symbol sampled on that edge.
//  - Frame: cfg_len data bits LSB first, parity bit if cfg_par_en, then STOP. cfg_len/cfg_par_en latched
//    at first bit-start of a word; cfg_len 0 or >MAX_BITS clamps to MAX_BITS.
//  - FSM: IDLE -(start)-> PULSE; PULSE -(strobe, data/parity)-> GAP; PULSE -(strobe, STOP)-> push, GAP;
//    GAP -(lines 11)-> WAIT (word open) or IDLE (word closed); WAIT -(start)-> PULSE;
//    PULSE -(symbol changes before strobe)-> push ERR_LEVEL, RESYNC; RESYNC -(STOP strobed)-> GAP.
//  - At STOP strobe: count != cfg_len+par -> ERR_LEN; parity even -> ERR_PAR; else ERR_OK.
//    A data/parity bit beyond cfg_len+par -> push ERR_LEN at that strobe, go RESYNC.
//  - Error entries carry m_data=0. Exactly one FIFO entry per word.
//  - Push occurs on the strobe edge; m_valid high from next cycle. Pop on valid&ready edge.
//  - Full + push without pop: word dropped, ovf=1. Full + push + pop same cycle: both accepted.
//  - rx_en=0: FSM forced IDLE, partial word discarded, FIFO/ovf kept; start ignored while rx_en=0.
//  - Pulse held past strobe is legal; GAP waits for 11.
//  - Reset mid-word: everything cleared, no entry pushed.
// CONFIGURATION
//  SL_RX_WATCHDOG_EN defined: cycle counter runs in GAP/WAIT/RESYNC, cleared on any symbol change;
//    reaching TIMEOUT pushes ERR_TIMEOUT (data 0) and returns IDLE.
//  Undefined: no counter; a stalled word holds busy=1 until the next STOP, rx_en=0 or rst.
// STRUCTURE
//  sl_pkg: ERR_OK=0, ERR_LEN=1, ERR_PAR=2, ERR_LEVEL=3, ERR_TIMEOUT=4; state enum
//    {IDLE,PULSE,GAP,WAIT,RESYNC}; symbol constants SYM_IDLE/ONE/ZERO/STOP.
//  Sub-module sl_word_fifo (width MAX_BITS+3, DEPTH, level output) holds storage; top holds sync+FSM.
// TESTING
//  1 cfg_len=8, par on, send 0xA5 + parity 1 + STOP -> one entry m_data=0x000000A5, m_err=0.
//  2 Same word, parity bit 0 -> m_err=2, m_data=0; 7 bits then STOP -> m_err=1.
//  3 m_ready=0, DEPTH=4, send 5 good words -> fifo_level=4, ovf=1; pops return words 1..4 in order.
//  4 3-cycle low pulse on sl1 (STROBE_POS=8) -> m_err=3; next well-formed word decodes ERR_OK.
//  5 3 bits then silence: with macro, TIMEOUT cycles later m_err=4, busy=0; without, busy stays 1.
//  6 rst pulse mid-word then full word 0x3C -> FIFO holds only 0x3C; rx_en=0 mid-word -> no entry.

Source files
------------

// File: rtl/sl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sl_pkg
//  Description : Shared constants for the SL serial-line receiver.
//                Holds the error codes carried with each FIFO entry, the FSM
//                state encoding and the synchronised line-pair symbol codes.
//  Revision    : 1.0  initial release
// ============================================================================
package sl_pkg;

    // Per-word error codes delivered on m_err
    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_PAR     = 3'd2;
    localparam logic [2:0] ERR_LEVEL   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    // Receiver FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PULSE  = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESYNC = 3'd4;

    // Line-pair symbols, encoded as {sl1, sl0}
    localparam logic [1:0] SYM_IDLE = 2'b11;
    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_ZERO = 2'b10;
    localparam logic [1:0] SYM_STOP = 2'b00;

    // Data value carried by a symbol (only meaningful for ONE/ZERO)
    function automatic logic sym_bit(input logic [1:0] sym);
        return (sym == SYM_ONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sl_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sl_word_fifo
//  Description : DEPTH-entry synchronous FIFO holding decoded SL words with
//                their error codes. Head is presented combinationally from
//                storage; a push that meets a full FIFO is only written when
//                a pop happens on the same edge.
//  Ports       : clk, rst         clock / asynchronous active-high reset
//                i_push, i_data   write strobe and entry
//                i_pop            read strobe (caller ensures o_valid)
//                o_data, o_valid  head entry and non-empty flag
//                o_full, o_level  full flag and occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module sl_word_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LVW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [AW-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [AW-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [LVW-1:0]   r_level_q,  w_level_d;
    logic             w_wr, w_rd;

    assign o_full  = (r_level_q == LVW'(DEPTH));
    assign o_valid = (r_level_q != '0);
    assign o_level = r_level_q;
    assign o_data  = r_mem_q[r_rd_ptr_q];

    // When full, a write is only legal if the head slot is freed on the same edge
    assign w_wr = i_push && (!o_full || i_pop);
    assign w_rd = i_pop && o_valid;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (w_wr) begin
            w_wr_ptr_d = r_wr_ptr_q + AW'(1);
        end
        if (w_rd) begin
            w_rd_ptr_d = r_rd_ptr_q + AW'(1);
        end
        case ({w_wr, w_rd})
            2'b10:   w_level_d = r_level_q + LVW'(1);
            2'b01:   w_level_d = r_level_q - LVW'(1);
            default: w_level_d = r_level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
        end
    end

    // Storage needs no reset: it is only observed through o_valid
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_q[r_wr_ptr_q] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sl_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sl_rx_fifo
//  Description : SL two-wire serial-line receiver. Synchronises the zeroes/
//                ones lines, decodes words of 1..MAX_BITS bits (LSB first)
//                with optional odd parity and a STOP symbol, and queues one
//                entry {err, data} per word in an sl_word_fifo.
//  Ports       : clk, rst             clock / async active-high reset
//                sl0_i, sl1_i         SL zeroes / ones lines (async, idle 1)
//                rx_en                receiver enable
//                cfg_len, cfg_par_en  word length / odd parity enable
//                m_valid/m_ready/m_data/m_err   FIFO head, valid/ready pop
//                fifo_level           occupied entries
//                busy                 word in progress
//                ovf, ovf_clr         sticky drop flag and its clear
//  Options     : SL_RX_WATCHDOG_EN    enables the TIMEOUT stall watchdog
//  Revision    : 1.0  initial release
// ============================================================================
module sl_rx_fifo
    import sl_pkg::*;
#(
    parameter int MAX_BITS   = 32,
    parameter int DEPTH      = 4,
    parameter int STROBE_POS = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sl0_i,
    input  logic                          sl1_i,
    input  logic                          rx_en,
    input  logic [$clog2(MAX_BITS+1)-1:0] cfg_len,
    input  logic                          cfg_par_en,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [MAX_BITS-1:0]           m_data,
    output logic [2:0]                    m_err,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_level,
    output logic                          busy,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int LW   = $clog2(MAX_BITS+1);
    localparam int CW   = LW + 1;                 // holds up to MAX_BITS+1 (data + parity)
    localparam int CNTW = $clog2(STROBE_POS+1);
    localparam int IW   = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int FW   = MAX_BITS + 3;

    // ------------------------------------------------------------------
    // Line synchronisers (reset to the idle level)
    // ------------------------------------------------------------------
    logic r_sl0_meta_q, r_sl0_sync_q, r_sl1_meta_q, r_sl1_sync_q;
    logic [1:0] r_sym_prev_q;
    logic [1:0] w_sym;
    logic       w_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sl0_meta_q <= 1'b1;
            r_sl0_sync_q <= 1'b1;
            r_sl1_meta_q <= 1'b1;
            r_sl1_sync_q <= 1'b1;
            r_sym_prev_q <= SYM_IDLE;
        end else begin
            r_sl0_meta_q <= sl0_i;
            r_sl0_sync_q <= r_sl0_meta_q;
            r_sl1_meta_q <= sl1_i;
            r_sl1_sync_q <= r_sl1_meta_q;
            r_sym_prev_q <= w_sym;
        end
    end

    assign w_sym   = {r_sl1_sync_q, r_sl0_sync_q};
    // A bit starts when the line pair leaves the idle 11 code
    assign w_start = rx_en && (r_sym_prev_q == SYM_IDLE) && (w_sym != SYM_IDLE);

    // ------------------------------------------------------------------
    // Decoder state
    // ------------------------------------------------------------------
    logic [2:0]          r_state_q,   w_state_d;
    logic [CNTW-1:0]     r_cnt_q,     w_cnt_d;
    logic [CW-1:0]       r_bitcnt_q,  w_bitcnt_d;
    logic [MAX_BITS-1:0] r_data_q,    w_data_d;
    logic                r_par_q,     w_par_d;
    logic [LW-1:0]       r_len_q,     w_len_d;
    logic                r_paren_q,   w_paren_d;
    logic                r_open_q,    w_open_d;
    logic [1:0]          r_sym_lat_q, w_sym_lat_d;
    logic                r_ovf_q,     w_ovf_d;

    logic                w_push;
    logic [2:0]          w_push_err;
    logic [MAX_BITS-1:0] w_push_data;
    logic [LW-1:0]       w_len_eff;
    logic [CW-1:0]       w_target;
    logic [2:0]          w_stop_err;
    logic [IW-1:0]       w_bit_idx;
    logic                w_bit;
    logic                w_strobe;
    logic                w_pop;
    logic                w_full;
    logic [FW-1:0]       w_head;

`ifdef SL_RX_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT+1);
    logic [WDW-1:0]      r_wd_q, w_wd_d;
`else
    logic                w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
`endif

    // Lengths of 0 or beyond MAX_BITS mean "full width"
    assign w_len_eff  = ((cfg_len == '0) || (cfg_len > LW'(MAX_BITS))) ? LW'(MAX_BITS) : cfg_len;
    assign w_target   = {1'b0, r_len_q} + {{(CW-1){1'b0}}, r_paren_q};
    // r_par_q accumulates data and parity bits; odd parity leaves it at 1
    assign w_stop_err = (r_bitcnt_q != w_target)   ? ERR_LEN :
                        (r_paren_q && !r_par_q)    ? ERR_PAR : ERR_OK;
    assign w_bit_idx  = r_bitcnt_q[IW-1:0];
    assign w_bit      = sym_bit(w_sym);
    assign w_strobe   = (r_cnt_q == CNTW'(STROBE_POS));

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_bitcnt_d  = r_bitcnt_q;
        w_data_d    = r_data_q;
        w_par_d     = r_par_q;
        w_len_d     = r_len_q;
        w_paren_d   = r_paren_q;
        w_open_d    = r_open_q;
        w_sym_lat_d = r_sym_lat_q;
        w_push      = 1'b0;
        w_push_err  = ERR_OK;
        w_push_data = '0;
`ifdef SL_RX_WATCHDOG_EN
        w_wd_d      = r_wd_q;
`endif

        case (r_state_q)
            ST_IDLE: begin
                if (w_start) begin
                    // Configuration is frozen for the whole word
                    w_len_d     = w_len_eff;
                    w_paren_d   = cfg_par_en;
                    w_bitcnt_d  = '0;
                    w_data_d    = '0;
                    w_par_d     = 1'b0;
                    w_open_d    = 1'b1;
                    w_sym_lat_d = w_sym;
                    w_cnt_d     = CNTW'(1);
                    w_state_d   = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (w_sym != r_sym_lat_q) begin
                    // Pulse ended or changed before the strobe
                    w_push     = 1'b1;
                    w_push_err = ERR_LEVEL;
                    w_cnt_d    = '0;
                    w_state_d  = ST_RESYNC;
                end else if (w_strobe) begin
                    if (w_sym == SYM_STOP) begin
                        w_push      = 1'b1;
                        w_push_err  = w_stop_err;
                        w_push_data = (w_stop_err == ERR_OK) ? r_data_q : '0;
                        w_open_d    = 1'b0;
                        w_state_d   = ST_GAP;
                    end else if (r_bitcnt_q >= w_target) begin
                        w_push     = 1'b1;
                        w_push_err = ERR_LEN;
                        w_cnt_d    = '0;
                        w_state_d  = ST_RESYNC;
                    end else begin
                        // Bits past cfg_len are the parity bit: counted, not stored
                        if (r_bitcnt_q < {1'b0, r_len_q}) begin
                            w_data_d[w_bit_idx] = w_bit;
                        end
                        w_par_d    = r_par_q ^ w_bit;
                        w_bitcnt_d = r_bitcnt_q + CW'(1);
                        w_state_d  = ST_GAP;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + CNTW'(1);
                end
            end
            ST_GAP: begin
                if (w_sym == SYM_IDLE) begin
                    w_state_d = r_open_q ? ST_WAIT : ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_start) begin
                    w_sym_lat_d = w_sym;
                    w_cnt_d     = CNTW'(1);
                    w_state_d   = ST_PULSE;
                end
            end
            ST_RESYNC: begin
                // Discard everything until a STOP is held through a full strobe interval
                if (w_sym != SYM_STOP) begin
                    w_cnt_d = '0;
                end else if (w_strobe) begin
                    w_open_d  = 1'b0;
                    w_state_d = ST_GAP;
                end else begin
                    w_cnt_d = r_cnt_q + CNTW'(1);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

`ifdef SL_RX_WATCHDOG_EN
        if ((r_state_q == ST_GAP) || (r_state_q == ST_WAIT) || (r_state_q == ST_RESYNC)) begin
            if (w_sym != r_sym_prev_q) begin
                w_wd_d = '0;
            end else if (r_wd_q == WDW'(TIMEOUT-1)) begin
                w_push      = 1'b1;
                w_push_err  = ERR_TIMEOUT;
                w_push_data = '0;
                w_open_d    = 1'b0;
                w_wd_d      = '0;
                w_state_d   = ST_IDLE;
            end else begin
                w_wd_d = r_wd_q + WDW'(1);
            end
        end else begin
            w_wd_d = '0;
        end
`endif

        // Disable abandons any partial word without producing an entry
        if (!rx_en) begin
            w_state_d = ST_IDLE;
            w_push    = 1'b0;
            w_open_d  = 1'b0;
`ifdef SL_RX_WATCHDOG_EN
            w_wd_d    = '0;
`endif
        end
    end

    // Set wins over clear when a word is dropped in the same cycle
    assign w_ovf_d = (r_ovf_q && !ovf_clr) || (w_push && w_full && !w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_cnt_q     <= '0;
            r_bitcnt_q  <= '0;
            r_data_q    <= '0;
            r_par_q     <= 1'b0;
            r_len_q     <= '0;
            r_paren_q   <= 1'b0;
            r_open_q    <= 1'b0;
            r_sym_lat_q <= SYM_IDLE;
            r_ovf_q     <= 1'b0;
`ifdef SL_RX_WATCHDOG_EN
            r_wd_q      <= '0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_bitcnt_q  <= w_bitcnt_d;
            r_data_q    <= w_data_d;
            r_par_q     <= w_par_d;
            r_len_q     <= w_len_d;
            r_paren_q   <= w_paren_d;
            r_open_q    <= w_open_d;
            r_sym_lat_q <= w_sym_lat_d;
            r_ovf_q     <= w_ovf_d;
`ifdef SL_RX_WATCHDOG_EN
            r_wd_q      <= w_wd_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    assign w_pop = m_valid && m_ready;

    sl_word_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({w_push_err, w_push_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (m_valid),
        .o_full  (w_full),
        .o_level (fifo_level)
    );

    // Head fields read as zero while empty
    assign m_data = m_valid ? w_head[MAX_BITS-1:0] : '0;
    assign m_err  = m_valid ? w_head[FW-1:MAX_BITS] : 3'd0;
    assign busy   = (r_state_q != ST_IDLE);
    assign ovf    = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sl_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sl_rx_fifo
//  Description : Self-checking bench for sl_rx_fifo. A table of single-word
//                frames with hand-computed results, followed by directed
//                sequences for overflow, glitch recovery, stalled words,
//                reset and disable mid-word.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sl_rx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        sl0_i, sl1_i;
    logic        rx_en;
    logic [5:0]  cfg_len;
    logic        cfg_par_en;
    logic        m_valid, m_ready;
    logic [31:0] m_data;
    logic [2:0]  m_err;
    logic [2:0]  fifo_level;
    logic        busy, ovf, ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sl_rx_fifo #(
        .MAX_BITS   (32),
        .DEPTH      (4),
        .STROBE_POS (8),
        .TIMEOUT    (256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sl0_i      (sl0_i),
        .sl1_i      (sl1_i),
        .rx_en      (rx_en),
        .cfg_len    (cfg_len),
        .cfg_par_en (cfg_par_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_err      (m_err),
        .fifo_level (fifo_level),
        .busy       (busy),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    typedef struct {
        logic [31:0] data;
        logic [5:0]  len;
        logic        par_en;
        int          nsend;     // data bits actually transmitted
        int          pmode;     // 0 no parity bit sent, 1 correct, 2 inverted
        logic [31:0] exp_data;
        logic [2:0]  exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One symbol: held 12 cycles (beyond strobe + sync latency), then 4 idle cycles
    task automatic send_sym(input logic [1:0] s);
        {sl1_i, sl0_i} = s;
        tick(12);
        {sl1_i, sl0_i} = 2'b11;
        tick(4);
    endtask

    task automatic send_bits(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            send_sym(d[i] ? 2'b01 : 2'b10);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [5:0] len, input logic par_en,
                             input int nsend, input int pmode);
        logic p;
        cfg_len    = len;
        cfg_par_en = par_en;
        p = 1'b1;
        for (int i = 0; i < nsend; i++) p = p ^ d[i];
        send_bits(d, nsend);
        if (pmode == 1) send_sym(p ? 2'b01 : 2'b10);
        if (pmode == 2) send_sym(p ? 2'b10 : 2'b01);
        send_sym(2'b00);
    endtask

    task automatic pop();
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; sl0_i = 1'b1; sl1_i = 1'b1; rx_en = 1'b1;
        cfg_len = 6'd8; cfg_par_en = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;

        vecs[0]  = '{32'h000000A5, 6'd8,  1'b1, 8,  1, 32'h000000A5, 3'd0};
        vecs[1]  = '{32'h000000A5, 6'd8,  1'b1, 8,  2, 32'h00000000, 3'd2};
        vecs[2]  = '{32'h000000A5, 6'd8,  1'b0, 7,  0, 32'h00000000, 3'd1};
        vecs[3]  = '{32'h0000003C, 6'd8,  1'b0, 8,  0, 32'h0000003C, 3'd0};
        vecs[4]  = '{32'hDEADBEEF, 6'd0,  1'b0, 32, 0, 32'hDEADBEEF, 3'd0};
        vecs[5]  = '{32'h00000001, 6'd1,  1'b1, 1,  1, 32'h00000001, 3'd0};
        vecs[6]  = '{32'h0000001F, 6'd4,  1'b0, 5,  0, 32'h00000000, 3'd1};
        vecs[7]  = '{32'h12345678, 6'd40, 1'b0, 32, 0, 32'h12345678, 3'd0};
        vecs[8]  = '{32'h0000FFFF, 6'd16, 1'b1, 16, 1, 32'h0000FFFF, 3'd0};
        vecs[9]  = '{32'h00000005, 6'd3,  1'b1, 3,  2, 32'h00000000, 3'd2};
        vecs[10] = '{32'h000000A5, 6'd8,  1'b1, 8,  0, 32'h00000000, 3'd1};

        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset state
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_ovf",   64'(ovf), 64'd0);
        check("rst_data",  64'(m_data), 64'd0);
        check("rst_err",   64'(m_err), 64'd0);

        // Single-word frames
        for (int i = 0; i < 11; i++) begin
            send_word(vecs[i].data, vecs[i].len, vecs[i].par_en, vecs[i].nsend, vecs[i].pmode);
            tick(2);
            check($sformatf("vec%0d_valid", i), 64'(m_valid), 64'd1);
            check($sformatf("vec%0d_data", i),  64'(m_data), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_err", i),   64'(m_err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_level", i), 64'(fifo_level), 64'd1);
            check($sformatf("vec%0d_busy", i),  64'(busy), 64'd0);
            pop();
            check($sformatf("vec%0d_popped", i), 64'(fifo_level), 64'd0);
        end

        // Overflow: five words into four entries, consumer stalled
        for (int w = 1; w <= 5; w++) begin
            send_word(32'(w), 6'd8, 1'b0, 8, 0);
        end
        tick(2);
        check("ovf_level", 64'(fifo_level), 64'd4);
        check("ovf_flag",  64'(ovf), 64'd1);
        for (int w = 1; w <= 4; w++) begin
            check($sformatf("ovf_pop%0d_data", w), 64'(m_data), 64'(w));
            pop();
        end
        check("ovf_drained", 64'(fifo_level), 64'd0);
        check("ovf_sticky",  64'(ovf), 64'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", 64'(ovf), 64'd0);

        // Short glitch on the ones line, then STOP to resync, then a good word
        cfg_len = 6'd8; cfg_par_en = 1'b0;
        {sl1_i, sl0_i} = 2'b01;
        tick(3);
        {sl1_i, sl0_i} = 2'b11;
        tick(10);
        check("glitch_valid", 64'(m_valid), 64'd1);
        check("glitch_err",   64'(m_err), 64'd3);
        check("glitch_data",  64'(m_data), 64'd0);
        check("glitch_busy",  64'(busy), 64'd1);
        pop();
        send_sym(2'b00);
        check("resync_busy",  64'(busy), 64'd0);
        check("resync_level", 64'(fifo_level), 64'd0);
        send_word(32'h5A, 6'd8, 1'b0, 8, 0);
        tick(2);
        check("after_glitch_err",  64'(m_err), 64'd0);
        check("after_glitch_data", 64'(m_data), 64'h5A);
        pop();

        // Stalled word: three bits then silence
        cfg_len = 6'd8; cfg_par_en = 1'b0;
        send_bits(32'h5, 3);
        tick(300);
`ifdef SL_RX_WATCHDOG_EN
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_err",   64'(m_err), 64'd4);
        check("stall_data",  64'(m_data), 64'd0);
        check("stall_busy",  64'(busy), 64'd0);
        pop();
`else
        check("stall_busy",  64'(busy), 64'd1);
        check("stall_level", 64'(fifo_level), 64'd0);
        rx_en = 1'b0;
        tick(1);
        rx_en = 1'b1;
        check("stall_abort_busy", 64'(busy), 64'd0);
`endif

        // Reset mid-word, then a full word
        send_bits(32'h3C, 3);
        check("midrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("midrst_level", 64'(fifo_level), 64'd0);
        check("midrst_busy",  64'(busy), 64'd0);
        send_word(32'h3C, 6'd8, 1'b0, 8, 0);
        tick(2);
        check("midrst_word_level", 64'(fifo_level), 64'd1);
        check("midrst_word_data",  64'(m_data), 64'h3C);
        check("midrst_word_err",   64'(m_err), 64'd0);
        pop();

        // Disable mid-word: partial word discarded
        send_bits(32'h3C, 3);
        rx_en = 1'b0;
        tick(1);
        check("dis_busy", 64'(busy), 64'd0);
        rx_en = 1'b1;
        tick(5);
        check("dis_level", 64'(fifo_level), 64'd0);
        check("dis_busy_after", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
